// File: rtl/display_scan_cold.sv
// Time-multiplexed seven-segment scanner: walks a one-cold, active-low anode select
// across N_DIGITS digits and decodes a frame-latched hex value to active-low segments.
module display_scan_cold #(
  parameter  int N_DIGITS     = 8,
  parameter  int PRESCALE     = 100000,
  parameter  int BLANK_CYCLES = 16,
  localparam int IW           = $clog2(N_DIGITS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   digit_mask,
  input  logic [N_DIGITS-1:0]   dp_in,
  output logic [N_DIGITS-1:0]   anodes,
  output logic [6:0]            segments,
  output logic                  dp,
  output logic [IW-1:0]         digit_idx,
  output logic                  frame_start
);

  localparam int CW = $clog2(PRESCALE);

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [4*N_DIGITS-1:0] snap_value;
  logic [N_DIGITS-1:0]   snap_mask;
  logic [N_DIGITS-1:0]   snap_dp;

  logic       cnt_wrap;
  logic       idx_wrap;
  logic       snap_take;
  logic       lit;
  logic [3:0] nibble;

  // Active-low hex font, bit 0 = a ... bit 6 = g.
  function automatic logic [6:0] hex7(input logic [3:0] h);
    hex7 = 7'h7F;
    case (h)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      4'hF: hex7 = 7'b0001110;
      default: hex7 = 7'h7F;
    endcase
  endfunction

  // NOTE: every always_comb output is a pure function of its inputs with no path
  // that leaves it unassigned, so no latch can be inferred.
  always_comb begin
    cnt_wrap  = (cnt == CW'(PRESCALE - 1));
    idx_wrap  = (idx == IW'(N_DIGITS - 1));
    snap_take = enable && (cnt == '0) && (idx == '0);
    lit       = enable && (cnt >= CW'(BLANK_CYCLES)) && snap_mask[idx];
    nibble    = snap_value[{idx, 2'b00} +: 4];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (enable) begin
      if (cnt_wrap) begin
        cnt <= '0;
        idx <= idx_wrap ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // NOTE: the frame registers are plain flops, not a RAM, so they take the async
  // reset like everything else and the display comes up blank and deterministic.
  // The snapshot lands at cnt==0, inside the blank window, so a frame change
  // never tears a lit digit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_value  <= '0;
      snap_mask   <= '0;
      snap_dp     <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= snap_take;
      if (snap_take) begin
        snap_value <= value;
        snap_mask  <= digit_mask;
        snap_dp    <= dp_in;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      anodes   <= '1;
      segments <= 7'h7F;
      dp       <= 1'b1;
    end else if (lit) begin
      anodes   <= ~(N_DIGITS'(1) << idx);
      segments <= hex7(nibble);
      dp       <= ~snap_dp[idx];
    end else begin
      anodes   <= '1;
      segments <= 7'h7F;
      dp       <= 1'b1;
    end
  end

  assign digit_idx = idx;

endmodule

// File: tb/tb_display_scan_cold.sv
// Self-checking bench for display_scan_cold: directed scenarios plus randomized
// stimulus, checked against a frame-position reference model.
module tb_display_scan_cold;

  localparam int N = 4;
  localparam int P = 8;
  localparam int B = 2;
  localparam int FRAME = N * P;

  localparam logic [6:0] HEX7 [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  digit_mask = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  anodes;
  logic [6:0]  segments;
  logic        dp;
  logic [1:0]  digit_idx;
  logic        frame_start;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  display_scan_cold #(.N_DIGITS(N), .PRESCALE(P), .BLANK_CYCLES(B)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .value       (value),
    .digit_mask  (digit_mask),
    .dp_in       (dp_in),
    .anodes      (anodes),
    .segments    (segments),
    .dp          (dp),
    .digit_idx   (digit_idx),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // Reference model: position within the frame counted in enabled cycles.
  int          m_pos;
  logic [15:0] m_val;
  logic [3:0]  m_mask;
  logic [3:0]  m_dpv;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic        e_fs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_pos  = 0;
    m_val  = '0;
    m_mask = '0;
    m_dpv  = '0;
    e_an   = 4'hF;
    e_seg  = 7'h7F;
    e_dp   = 1'b1;
    e_fs   = 1'b0;
  endtask

  task automatic model_edge();
    int d;
    int c;
    e_an  = 4'hF;
    e_seg = 7'h7F;
    e_dp  = 1'b1;
    e_fs  = 1'b0;
    if (enable) begin
      d = m_pos / P;
      c = m_pos % P;
      if (c >= B && m_mask[d]) begin
        e_an  = ~(4'b0001 << d);
        e_seg = HEX7[m_val[4*d +: 4]];
        e_dp  = ~m_dpv[d];
      end
      if (m_pos == 0) begin
        e_fs   = 1'b1;
        m_val  = value;
        m_mask = digit_mask;
        m_dpv  = dp_in;
      end
      m_pos = (m_pos + 1) % FRAME;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_edge();
    #1;
    cyc++;
    check("outs", 32'({anodes, segments, dp, frame_start, digit_idx}),
          32'({e_an, e_seg, e_dp, e_fs, 2'(m_pos / P)}));
    check("onecold", 32'($countones(~anodes) <= 1), 32'd1);
  endtask

  task automatic wait_fs(output int at);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!frame_start && n < 200);
    check("fs_seen", 32'(frame_start), 32'd1);
    at = cyc;
  endtask

  // Runs the 31 cycles after a frame_start, counting digit-2 lit cycles and dp activity.
  task automatic run_frame(output int lit2, output int dplow, output int stray);
    lit2 = 0;
    dplow = 0;
    stray = 0;
    for (int k = 0; k < FRAME - 1; k++) begin
      step();
      if (anodes == 4'b1011) lit2++;
      if (dp == 1'b0) dplow++;
      if (dp == 1'b0 && anodes != 4'b1011) stray++;
    end
  endtask

  task automatic async_reset_pulse();
    #2 reset_n = 1'b0;
    #1;
    check("rst_async_an", 32'(anodes), 32'hF);
    check("rst_async_seg", 32'(segments), 32'h7F);
    check("rst_async_dp", 32'(dp), 32'd1);
    model_reset();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    int fs_cyc;
    int at;
    int lit2;
    int dplow;
    int stray;

    model_reset();
    enable     = 1'b1;
    value      = 16'h1234;
    digit_mask = 4'hF;
    dp_in      = 4'h0;

    repeat (5) step();
    check("rst_an", 32'(anodes), 32'hF);
    check("rst_seg", 32'(segments), 32'h7F);
    check("rst_dp", 32'(dp), 32'd1);
    check("rst_fs", 32'(frame_start), 32'd0);
    reset_n = 1'b1;

    step();
    check("fs_first", 32'(frame_start), 32'd1);
    fs_cyc = cyc;
    step();
    check("s0_blank", 32'(anodes), 32'hF);
    step();
    check("s0_an", 32'(anodes), 32'b1110);
    check("s0_seg", 32'(segments), 32'b0011001);
    repeat (7) step();
    step();
    check("s1_an", 32'(anodes), 32'b1101);
    check("s1_seg", 32'(segments), 32'b0110000);
    wait_fs(at);
    check("fs_period", 32'(at - fs_cyc), 32'd32);

    digit_mask = 4'b1011;
    dp_in      = 4'b0100;
    wait_fs(at);
    run_frame(lit2, dplow, stray);
    check("mask_dark", 32'(lit2), 32'd0);
    check("mask_dp_off", 32'(dplow), 32'd0);

    digit_mask = 4'hF;
    wait_fs(at);
    run_frame(lit2, dplow, stray);
    check("slot2_lit", 32'(lit2), 32'd6);
    check("dp_lit", 32'(dplow), 32'd6);
    check("dp_stray", 32'(stray), 32'd0);

    wait_fs(at);
    fs_cyc = at;
    repeat (11) step();
    value = 16'hABCD;
    step();
    check("hold_seg", 32'(segments), 32'b0110000);
    repeat (19) step();
    wait_fs(at);
    check("fs_period2", 32'(at - fs_cyc), 32'd32);
    fs_cyc = at;
    repeat (2) step();
    check("new_an", 32'(anodes), 32'b1110);
    check("new_seg", 32'(segments), 32'b0100001);

    repeat (18) step();
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check("hold_dark", 32'(anodes), 32'hF);
      check("hold_idx", 32'(digit_idx), 32'd2);
    end
    enable = 1'b1;
    wait_fs(at);
    check("fs_after_hold", 32'(at - fs_cyc), 32'd42);

    repeat (3) step();
    check("pre_rst_lit", 32'(anodes), 32'b1110);
    async_reset_pulse();
    check("rst_idx", 32'(digit_idx), 32'd0);
    step();
    check("fs_after_rst", 32'(frame_start), 32'd1);

    for (int i = 0; i < 1500; i++) begin
      step();
      if ($urandom_range(0, 9) == 0) value = 16'($urandom);
      if ($urandom_range(0, 29) == 0) digit_mask = 4'($urandom);
      if ($urandom_range(0, 29) == 0) dp_in = 4'($urandom);
      if (enable) begin
        if ($urandom_range(0, 39) == 0) enable = 1'b0;
      end else begin
        if ($urandom_range(0, 3) == 0) enable = 1'b1;
      end
      if ($urandom_range(0, 299) == 0) async_reset_pulse();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
